// File: rtl/mag_window_stats.sv
// rtl/mag_window_stats.sv - moving-window average, peak scan and hysteresis alarm for magnitude samples
module mag_window_stats #(
  parameter int DEPTH      = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int HYST       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] mag_in,
  input  logic       mag_valid,
  output logic       mag_ready,
  input  logic [7:0] threshold,
  output logic [7:0] avg_out,
  output logic [7:0] peak_out,
  output logic       alarm,
  output logic       out_valid,
  output logic       win_full
);

  localparam int SW = 8 + LOG2_DEPTH;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [LOG2_DEPTH:0]   COUNT_FULL = (LOG2_DEPTH + 1)'(DEPTH);
  localparam logic [LOG2_DEPTH-1:0] SCAN_LAST  = LOG2_DEPTH'(DEPTH - 1);
  localparam logic [8:0]            HYST_W     = 9'(HYST);

  logic [7:0]            mem_q [DEPTH];
  logic [7:0]            mem_d [DEPTH];
  logic [SW-1:0]         sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] scan_idx_q, scan_idx_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic [0:0]            state_q, state_d;
  logic [7:0]            peak_acc_q, peak_acc_d;
  logic [7:0]            avg_q, avg_d;
  logic [7:0]            peak_q, peak_d;
  logic                  alarm_q, alarm_d;
  logic                  out_valid_q, out_valid_d;

  logic                  accept;
  logic [7:0]            scan_val;
  logic [7:0]            scan_max;
  logic [7:0]            avg_new;
  logic [7:0]            thr_lo;

  assign mag_ready = (state_q == IDLE) && !clr;
  assign accept    = mag_valid && mag_ready;
  assign avg_out   = avg_q;
  assign peak_out  = peak_q;
  assign alarm     = alarm_q;
  assign out_valid = out_valid_q;
  assign win_full  = (count_q == COUNT_FULL);

  // Scan datapath, window average and the saturated hysteresis release level
  always_comb begin
    scan_val = mem_q[scan_idx_q];
    scan_max = (scan_val > peak_acc_q) ? scan_val : peak_acc_q;
    // The sum is already updated with the new sample by the time the scan finishes
    avg_new  = sum_q[SW-1:LOG2_DEPTH];
    if ({1'b0, threshold} > HYST_W) begin
      thr_lo = threshold - HYST_W[7:0];
    end else begin
      thr_lo = 8'd0;
    end
  end

  // Next-state logic: clear, sample accept, and the peak scan with final update
  always_comb begin
    mem_d       = mem_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    scan_idx_d  = scan_idx_q;
    count_d     = count_q;
    state_d     = state_q;
    peak_acc_d  = peak_acc_q;
    avg_d       = avg_q;
    peak_d      = peak_q;
    alarm_d     = alarm_q;
    out_valid_d = 1'b0;

    if (clr) begin
      // Abandon any scan in progress; no result pulse for it
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = 8'd0;
      end
      sum_d      = '0;
      wr_ptr_d   = '0;
      scan_idx_d = '0;
      count_d    = '0;
      state_d    = IDLE;
      peak_acc_d = 8'd0;
      avg_d      = 8'd0;
      peak_d     = 8'd0;
      alarm_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Running sum: drop the evicted slot, add the new sample
            sum_d            = sum_q - SW'(mem_q[wr_ptr_q]) + SW'(mag_in);
            mem_d[wr_ptr_q]  = mag_in;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            if (count_q != COUNT_FULL) begin
              count_d = count_q + 1'b1;
            end
            scan_idx_d = '0;
            peak_acc_d = 8'd0;
            state_d    = SCAN;
          end
        end
        SCAN: begin
          peak_acc_d = scan_max;
          scan_idx_d = scan_idx_q + 1'b1;
          if (scan_idx_q == SCAN_LAST) begin
            // Final compare: publish all results together
            peak_d      = scan_max;
            avg_d       = avg_new;
            out_valid_d = 1'b1;
            state_d     = IDLE;
            if (avg_new >= threshold) begin
              alarm_d = 1'b1;
            end else if (avg_new < thr_lo) begin
              alarm_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      scan_idx_q  <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      peak_acc_q  <= 8'd0;
      avg_q       <= 8'd0;
      peak_q      <= 8'd0;
      alarm_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      scan_idx_q  <= scan_idx_d;
      count_q     <= count_d;
      state_q     <= state_d;
      peak_acc_q  <= peak_acc_d;
      avg_q       <= avg_d;
      peak_q      <= peak_d;
      alarm_q     <= alarm_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
